// File: rtl/soc_system_step_motor_pkg.sv
// Shared definitions for the step-pulse sequencer: register map, bit positions, FSM states.
package soc_system_step_motor_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STEPS  = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_DIR    = 1;
    localparam int unsigned CTRL_START  = 2;
    localparam int unsigned CTRL_BUSY   = 2;
    localparam int unsigned CTRL_ABORT  = 3;
    localparam int unsigned CTRL_IE     = 4;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } step_state_e;

endpackage

// File: rtl/soc_system_step_motor_if.sv
// Avalon-MM slave bus bundle for the step-pulse sequencer.
interface soc_system_step_motor_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input  readdata);
    modport slave  (input  address, input  chipselect, input  write_n, input  writedata,
                    output readdata);
endinterface

// File: rtl/soc_system_step_motor_timer.sv
// Loadable down-counter with zero flag; shared by the SETUP, HIGH and LOW phases.
module soc_system_step_motor_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/soc_system_step_motor_ctrl.sv
// Avalon-MM step-pulse sequencer for one stepper axis driving {enable, dir, step}.
// Optional interrupt output is built when STEP_MOTOR_IRQ_EN is defined.
module soc_system_step_motor_ctrl
    import soc_system_step_motor_pkg::*;
#(
    parameter int unsigned PULSE_W   = 50,
    parameter int unsigned DIR_SETUP = 10,
    parameter int unsigned STEP_W    = 24,
    parameter int unsigned PERIOD_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_step_motor_if.slave    avs,
    output logic [2:0]                out_port
`ifdef STEP_MOTOR_IRQ_EN
    ,
    output logic                      irq
`endif
);

    step_state_e         state;
    logic                enable;
    logic                dir_shadow;
    logic                dir_act;
    logic                step_q;
    logic                done;
    logic                aborted;
    logic [STEP_W-1:0]   steps_load;
    logic [STEP_W-1:0]   remaining;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] low_m1;
    logic [PERIOD_W-1:0] tmr_val;
    logic                tmr_load;
    logic                tmr_zero;
    logic                busy;
    logic                wr_en;
    logic                wr_ctrl;
    logic                wr_steps;
    logic                wr_period;
    logic                wr_status;
    logic                start_req;
    logic                stop_req;
    logic [31:0]         wd;
    logic [31:0]         rdata;
    logic                unused_wd;
`ifdef STEP_MOTOR_IRQ_EN
    logic                ie;
`endif

    assign wd        = avs.writedata;
    assign unused_wd = ^wd;
    assign busy      = (state != ST_IDLE);
    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign wr_ctrl   = wr_en && (avs.address == REG_CTRL);
    assign wr_steps  = wr_en && (avs.address == REG_STEPS);
    assign wr_period = wr_en && (avs.address == REG_PERIOD);
    assign wr_status = wr_en && (avs.address == REG_STATUS);

    // ABORT dominates START in the same write; enable is taken from the write itself.
    assign start_req = wr_ctrl && !busy && wd[CTRL_START] && !wd[CTRL_ABORT] && wd[CTRL_ENABLE];
    assign stop_req  = wr_ctrl && busy && (wd[CTRL_ABORT] || !wd[CTRL_ENABLE]);

    // Low phase length minus one, clamped so the low phase lasts at least one cycle.
    assign low_m1 = (period > PERIOD_W'(PULSE_W)) ? (period - PERIOD_W'(PULSE_W + 1)) : '0;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start_req && (steps_load != '0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = PERIOD_W'(DIR_SETUP - 1);
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = PERIOD_W'(PULSE_W - 1);
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = low_m1;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    soc_system_step_motor_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            enable     <= 1'b0;
            dir_shadow <= 1'b0;
            dir_act    <= 1'b0;
            step_q     <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            steps_load <= '0;
            remaining  <= '0;
            period     <= '0;
`ifdef STEP_MOTOR_IRQ_EN
            ie         <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                enable     <= wd[CTRL_ENABLE];
                dir_shadow <= wd[CTRL_DIR];
`ifdef STEP_MOTOR_IRQ_EN
                ie         <= wd[CTRL_IE];
`endif
            end
            if (wr_steps) begin
                steps_load <= wd[STEP_W-1:0];
            end
            if (wr_period) begin
                period <= wd[PERIOD_W-1:0];
            end
            if (wr_status) begin
                if (wd[STAT_DONE]) begin
                    done <= 1'b0;
                end
                if (wd[STAT_ABORTED]) begin
                    aborted <= 1'b0;
                end
            end

            // Sticky-flag sets below are placed after W1C so a same-cycle event wins.
            if (stop_req) begin
                state   <= ST_IDLE;
                step_q  <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        step_q <= 1'b0;
                        if (start_req) begin
                            if (steps_load == '0) begin
                                done <= 1'b1;
                            end else begin
                                dir_act   <= dir_shadow;
                                remaining <= steps_load;
                                done      <= 1'b0;
                                aborted   <= 1'b0;
                                state     <= ST_SETUP;
                            end
                        end
                    end
                    ST_SETUP: begin
                        if (tmr_zero) begin
                            state  <= ST_HIGH;
                            step_q <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (tmr_zero) begin
                            state  <= ST_LOW;
                            step_q <= 1'b0;
                            if (remaining != '0) begin
                                remaining <= remaining - STEP_W'(1);
                            end
                        end
                    end
                    ST_LOW: begin
                        if (tmr_zero) begin
                            if (remaining == '0) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state  <= ST_HIGH;
                                step_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_port = {enable, (busy ? dir_act : dir_shadow), step_q};

`ifdef STEP_MOTOR_IRQ_EN
    assign irq = ie & (done | aborted);
`endif

    always_comb begin
        rdata = '0;
        case (avs.address)
            REG_CTRL: begin
                rdata[CTRL_ENABLE] = enable;
                rdata[CTRL_DIR]    = dir_shadow;
                rdata[CTRL_BUSY]   = busy;
`ifdef STEP_MOTOR_IRQ_EN
                rdata[CTRL_IE]     = ie;
`endif
            end
            // Residual count stays visible after an abort until the flag is cleared.
            REG_STEPS:  rdata[STEP_W-1:0]   = (busy || aborted) ? remaining : steps_load;
            REG_PERIOD: rdata[PERIOD_W-1:0] = period;
            REG_STATUS: begin
                rdata[STAT_BUSY]    = busy;
                rdata[STAT_DONE]    = done;
                rdata[STAT_ABORTED] = aborted;
            end
            default: rdata = '0;
        endcase
    end

    assign avs.readdata = rdata;

endmodule

// File: tb/tb_soc_system_step_motor_ctrl.sv
// Scoreboard bench for soc_system_step_motor_ctrl: register reads and step-pulse timing.
module tb_soc_system_step_motor_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] out_port;
`ifdef STEP_MOTOR_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;

    soc_system_step_motor_if bus ();

    soc_system_step_motor_ctrl #(
        .PULSE_W   (50),
        .DIR_SETUP (10),
        .STEP_W    (24),
        .PERIOD_W  (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus.slave),
        .out_port (out_port)
`ifdef STEP_MOTOR_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    typedef struct {
        string       name;
        bit          is_port;
        logic [31:0] val;
    } rd_exp_t;

    // kind: 0 = first rise (cycles after START), 1 = high width, 2 = low width
    typedef struct {
        string name;
        int    kind;
        int    val;
        bit    dir;
    } ev_t;

    rd_exp_t rd_q[$];
    ev_t     ev_q[$];
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      mark = 0;
    bit      chk_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: step event not matching expected sequence", name);
    endtask

    // Register/port monitor
    always @(negedge clk) begin
        rd_exp_t e;
        if (chk_req) begin
            if (rd_q.size() == 0) begin
                unexpected("read queue empty");
            end else begin
                e = rd_q.pop_front();
                check(e.name, e.is_port ? {29'd0, out_port} : bus.readdata, e.val);
            end
        end
    end

    // Step-pulse monitor
    bit prev_step = 1'b0;
    int hi_cnt = 0;
    int lo_cnt = 0;
    always @(negedge clk) begin
        ev_t e;
        if (out_port[0] && !prev_step) begin
            if (ev_q.size() == 0) begin
                unexpected("extra rise");
            end else begin
                e = ev_q.pop_front();
                if (e.kind == 0)      check(e.name, cyc - mark, e.val);
                else if (e.kind == 2) check(e.name, lo_cnt, e.val);
                else                  unexpected(e.name);
            end
            hi_cnt = 1;
        end else if (out_port[0]) begin
            hi_cnt++;
        end else if (prev_step) begin
            if (ev_q.size() == 0) begin
                unexpected("extra fall");
            end else begin
                e = ev_q.pop_front();
                if (e.kind == 1) begin
                    check(e.name, hi_cnt, e.val);
                    check({e.name, " dir"}, {31'd0, out_port[1]}, {31'd0, e.dir});
                end else begin
                    unexpected(e.name);
                end
            end
            lo_cnt = 1;
        end else begin
            lo_cnt++;
        end
        prev_step = out_port[0];
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string n);
        rd_q.push_back('{n, 1'b0, exp});
        bus.address    = a;
        bus.chipselect = 1'b1;
        chk_req        = 1'b1;
        @(posedge clk);
        #1;
        chk_req        = 1'b0;
        bus.chipselect = 1'b0;
    endtask

    task automatic port(input logic [2:0] exp, input string n);
        rd_q.push_back('{n, 1'b1, {29'd0, exp}});
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input string n, input int kind, input int val, input bit dir);
        ev_q.push_back('{n, kind, val, dir});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rd(2'd0, 32'd0, "rst ctrl");
        rd(2'd1, 32'd0, "rst steps");
        rd(2'd2, 32'd0, "rst period");
        rd(2'd3, 32'd0, "rst status");
        port(3'b000, "rst port");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 steps, period 200, dir=1; mid-move dir=0 + START ignored
        wr(2'd0, 32'h3);
        port(3'b110, "enabled idle port");
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd200);
        rd(2'd2, 32'd200, "period rb");
        rd(2'd1, 32'd3, "steps rb");
        push_ev("m1 rise", 0, 10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_ev($sformatf("m1 high%0d", i), 1, 50, 1'b1);
            if (i < 2) push_ev($sformatf("m1 low%0d", i), 2, 150, 1'b1);
        end
        wr(2'd0, 32'h7);
        mark = cyc;
        rd(2'd0, 32'h7, "m1 ctrl busy");
        at(mark + 20);
        rd(2'd1, 32'd3, "m1 remaining high1");
        at(mark + 100);
        rd(2'd1, 32'd2, "m1 remaining low1");
        at(mark + 300);
        wr(2'd0, 32'h5);
        rd(2'd0, 32'h5, "m1 restart ignored");
        port(3'b110, "m1 dir held");
        at(mark + 609);
        rd(2'd3, 32'h1, "m1 busy before end");
        rd(2'd3, 32'h2, "m1 done");
        port(3'b100, "m1 dir shadow idle");
        rd(2'd1, 32'd3, "m1 steps idle");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "done w1c");

        // START with zero steps, then START with enable=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h5);
        rd(2'd3, 32'h2, "zero-step done");
        rd(2'd0, 32'h1, "zero-step ctrl");
        wr(2'd3, 32'h2);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd20);
        wr(2'd0, 32'h4);
        rd(2'd3, 32'h0, "disabled start status");
        rd(2'd0, 32'h0, "disabled start ctrl");
        port(3'b000, "disabled port");

        // Short period: low phase clamped to one cycle
        wr(2'd0, 32'h3);
        push_ev("m2 rise", 0, 10, 1'b1);
        push_ev("m2 high0", 1, 50, 1'b1);
        push_ev("m2 low0", 2, 1, 1'b1);
        push_ev("m2 high1", 1, 50, 1'b1);
        wr(2'd0, 32'h7);
        mark = cyc;
        at(mark + 111);
        rd(2'd3, 32'h1, "m2 busy before end");
        rd(2'd3, 32'h2, "m2 done");
        wr(2'd3, 32'h2);

        // Clearing enable during the first HIGH aborts
        wr(2'd1, 32'd100);
        wr(2'd2, 32'd200);
        push_ev("m3 rise", 0, 10, 1'b1);
        push_ev("m3 cut high", 1, 11, 1'b1);
        wr(2'd0, 32'h7);
        mark = cyc;
        at(mark + 20);
        wr(2'd0, 32'h2);
        rd(2'd3, 32'h4, "m3 aborted");
        rd(2'd1, 32'd100, "m3 residual");
        port(3'b010, "m3 port");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h0, "aborted w1c");

        // ABORT during the 5th low phase
        wr(2'd0, 32'h3);
        push_ev("m4 rise", 0, 10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push_ev($sformatf("m4 high%0d", i), 1, 50, 1'b1);
            if (i < 4) push_ev($sformatf("m4 low%0d", i), 2, 150, 1'b1);
        end
        wr(2'd0, 32'h7);
        mark = cyc;
        at(mark + 899);
        wr(2'd0, 32'hB);
        rd(2'd3, 32'h4, "m4 aborted");
        rd(2'd1, 32'd95, "m4 residual");
        rd(2'd0, 32'h3, "m4 ctrl");
        wr(2'd0, 32'hF);
        rd(2'd3, 32'h4, "abort+start no move");
        wr(2'd3, 32'h4);

        // Asynchronous reset in the middle of a HIGH phase
        wr(2'd1, 32'd3);
        push_ev("m5 rise", 0, 10, 1'b1);
        push_ev("m5 reset high", 1, 20, 1'b0);
        wr(2'd0, 32'h7);
        mark = cyc;
        at(mark + 30);
        reset_n = 1'b0;
        port(3'b000, "async rst port");
        rd(2'd0, 32'h0, "async rst ctrl");
        rd(2'd1, 32'd0, "async rst steps");
        rd(2'd3, 32'h0, "async rst status");
        rd(2'd2, 32'h0, "async rst period");
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("events drained", ev_q.size() + rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
